// File: rtl/iface_data_fifo.sv
// ---------------------------------------------------------------------------
// iface_data_fifo
//   Byte-stream FIFO that sits directly upstream of the TestIface data bus.
//   Bytes from a producer enter over a valid/ready handshake. They are
//   presented in FIFO order to the stage that drives the interface data bus,
//   so producer bursts are decoupled from consumer back-pressure.
//
//   Optional feature macro: IFACE_FIFO_STATS_EN
//     When defined, the block adds an 8-bit saturating overflow counter.
//     It counts edges where the producer offered data while the FIFO was full.
//
// Ports
//   clk        in   1    rising-edge clock
//   rst_n      in   1    asynchronous active-low reset
//   in_data    in   DW   write data from producer
//   in_valid   in   1    producer offers in_data
//   in_ready   out  1    FIFO can accept (count < DEPTH)
//   out_data   out  DW   head entry toward interface data bus
//   out_valid  out  1    head entry is valid (count != 0)
//   out_ready  in   1    interface side consumes head
//   count      out  CW   current occupancy, 0..DEPTH
//   ovf_cnt    out  8    overflow attempts, saturating (IFACE_FIFO_STATS_EN only)
// ---------------------------------------------------------------------------
module iface_data_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] count
`ifdef IFACE_FIFO_STATS_EN
  ,
  output logic [7:0]    ovf_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_reg;
  logic [DW-1:0] last_reg;
  logic          push;
  logic          pop;

  // Handshake flags are decoded from the registered occupancy only. This
  // keeps in_valid and out_ready off any combinational path to the outputs.
  assign in_ready  = (count_reg != CW'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_reg;

  // While non-empty, the head is read straight from storage. The head slot
  // cannot be overwritten while data is waiting, because a push only targets
  // it when the FIFO is empty. Once the FIFO drains, the output shows the
  // last popped byte instead of whatever stale entry rd_ptr now points at.
  assign out_data = out_valid ? mem[rd_ptr] : last_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // DEPTH is a power of two, so the natural pointer rollover wraps
  // DEPTH-1 back to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_reg <= '0;
      last_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        last_reg <= mem[rd_ptr];
      end
      if (push && !pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop && !push) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

`ifdef IFACE_FIFO_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (in_valid && !in_ready && (ovf_cnt != 8'hFF)) begin
      ovf_cnt <= ovf_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_iface_data_fifo.sv
// ---------------------------------------------------------------------------
// tb_iface_data_fifo
//   Directed self-checking bench for iface_data_fifo (DW=8, DEPTH=4).
//   Inputs are driven 1 ns after each rising edge. Outputs are checked in
//   that same window, away from the active edge.
// ---------------------------------------------------------------------------
module tb_iface_data_fifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] count;
`ifdef IFACE_FIFO_STATS_EN
  logic [7:0] ovf_cnt;
`endif

  int checks = 0;
  int errors = 0;

  iface_data_fifo #(.DW(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
`ifdef IFACE_FIFO_STATS_EN
    ,
    .ovf_cnt   (ovf_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      $display("[%0t] check %s obs=%0h", $time, tag, obs);
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] head;

  initial begin
    rst_n     = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // 1. Reset state
    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_count",     {29'd0, count},     32'd0);
    chk("rst_out_data",  {24'd0, out_data},  32'h00);
`ifdef IFACE_FIFO_STATS_EN
    chk("rst_ovf",       {24'd0, ovf_cnt},   32'd0);
`endif
    #9 rst_n = 1'b1;
    step();

    // 2. Single byte, then pop; the output must hold the popped byte
    in_data = 8'h55; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("single_valid", {31'd0, out_valid}, 32'd1);
    chk("single_data",  {24'd0, out_data},  32'h55);
    chk("single_count", {29'd0, count},     32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("single_pop_count", {29'd0, count},     32'd0);
    chk("single_pop_valid", {31'd0, out_valid}, 32'd0);
    chk("single_hold_data", {24'd0, out_data},  32'h55);

    // Empty with out_ready=1: the pushed byte is not popped in the same cycle
    in_data = 8'h66; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("empty_nopass_count", {29'd0, count},    32'd1);
    chk("empty_nopass_data",  {24'd0, out_data}, 32'h66);
    step();
    out_ready = 1'b0;
    chk("empty_pop_count", {29'd0, count},    32'd0);
    chk("empty_pop_hold",  {24'd0, out_data}, 32'h66);

    // 3. Fill and check order
    for (int i = 1; i <= 4; i++) begin
      in_data = 8'(i * 8'h11); in_valid = 1'b1;
      step();
    end
    chk("full_count",    {29'd0, count},    32'd4);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    in_data = 8'h99;  // rejected while full
    step();
    in_valid = 1'b0;
    chk("full_ovf_count", {29'd0, count},    32'd4);
    chk("full_head",      {24'd0, out_data}, 32'h11);
`ifdef IFACE_FIFO_STATS_EN
    chk("full_ovf_cnt",   {24'd0, ovf_cnt},  32'd1);
`endif
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_data", {24'd0, out_data}, 32'(i * 8'h11));
      step();
      if (i == 1) chk("drain_in_ready_after_full", {31'd0, in_ready}, 32'd1);
    end
    out_ready = 1'b0;
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_count", {29'd0, count},     32'd0);
    chk("drain_hold",  {24'd0, out_data},  32'h44);

    // 4. Hold count=2 through 10 push+pop cycles across the pointer wrap
    exp_q = {};
    for (int i = 0; i < 2; i++) begin
      in_data = 8'hB0 + 8'(i); in_valid = 1'b1;
      exp_q.push_back(in_data);
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'hA0 + 8'(i);
      exp_q.push_back(in_data);
      head = exp_q.pop_front();
      chk("wrap_data", {24'd0, out_data}, {24'd0, head});
      step();
      chk("wrap_count", {29'd0, count}, 32'd2);
    end
    in_valid = 1'b0;
    while (exp_q.size() > 0) begin
      head = exp_q.pop_front();
      chk("wrap_tail", {24'd0, out_data}, {24'd0, head});
      step();
    end
    out_ready = 1'b0;
    chk("wrap_empty", {31'd0, out_valid}, 32'd0);

    // 5. Asynchronous reset mid-burst
    for (int i = 1; i <= 3; i++) begin
      in_data = 8'hC0 + 8'(i); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    chk("pre_rst_count", {29'd0, count}, 32'd3);
    #1 rst_n = 1'b0;  // between edges
    #1;
    chk("arst_count",    {29'd0, count},     32'd0);
    chk("arst_valid",    {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready},  32'd1);
    chk("arst_data",     {24'd0, out_data},  32'h00);
    #1 rst_n = 1'b1;
    step();
    in_data = 8'hD7; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("post_rst_count", {29'd0, count},    32'd1);
    chk("post_rst_data",  {24'd0, out_data}, 32'hD7);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_rst_empty", {29'd0, count}, 32'd0);

`ifdef IFACE_FIFO_STATS_EN
    // 6. Overflow counter saturation
    chk("sat_ovf_start", {24'd0, ovf_cnt}, 32'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(i);
      step();
    end
    for (int i = 0; i < 300; i++) step();
    in_valid = 1'b0;
    chk("sat_ovf", {24'd0, ovf_cnt}, 32'd255);
    chk("sat_count", {29'd0, count}, 32'd4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
